// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Mode encodings, FSM states and helpers for mux_scan_sampler.
// Revision    : 1.0  initial release
// ============================================================================
package mux_scan_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Reserved encoding 2'b11 falls through to manual behaviour.
    function automatic logic is_scan_mode(input logic [1:0] mode);
        return (mode == MODE_SCAN) || (mode == MODE_SWEEP);
    endfunction

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_scan_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sampler_if
// Description : Channel inputs, run controls and valid/ready sample output.
// Revision    : 1.0  initial release
// ============================================================================
interface mux_scan_sampler_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 1
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*DATA_W-1:0] din;
    logic                   en;
    logic [1:0]             mode;
    logic [SEL_W-1:0]       sel;
    logic [N_CH-1:0]        ch_mask;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_valid;
    logic                   out_ready;
    logic                   done;

    modport master (
        output din, en, mode, sel, ch_mask, out_ready,
        input  out_data, out_ch, out_valid, done
    );

    modport slave (
        input  din, en, mode, sel, ch_mask, out_ready,
        output out_data, out_ch, out_valid, done
    );

endinterface : mux_scan_sampler_if
`default_nettype wire

// File: rtl/mux_scan_next.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_next
// Description : Circular priority finder: first masked-in channel after ptr
//               (or from index 0 when i_from_zero is set).
// Revision    : 1.0  initial release
// ============================================================================
module mux_scan_next #(
    parameter  int N_CH  = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  wire logic [SEL_W-1:0] i_ptr,
    input  wire logic [N_CH-1:0]  i_ch_mask,
    input  wire logic             i_from_zero,
    output logic      [SEL_W-1:0] o_next,
    output logic                  o_any,
    output logic                  o_wrapped
);

    logic [SEL_W-1:0] w_start;
    logic [SEL_W-1:0] w_idx;

    // Walk offsets high-to-low so the smallest offset from w_start wins;
    // N_CH is a power of two, so SEL_W-bit addition wraps for free.
    always_comb begin
        w_start = i_from_zero ? '0 : (i_ptr + SEL_W'(1));
        w_idx   = '0;
        o_next  = '0;
        o_any   = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_idx = w_start + SEL_W'(i);
            if (i_ch_mask[w_idx]) begin
                o_next = w_idx;
                o_any  = 1'b1;
            end
        end
    end

    assign o_wrapped = o_any && (o_next <= i_ptr);

endmodule : mux_scan_next
`default_nettype wire

// File: rtl/mux_scan_sampler.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sampler
// Description : Registered N-channel mux with manual, round-robin and
//               single-sweep selection, valid/ready output tagged by channel.
// Revision    : 1.0  initial release
// ============================================================================
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mux_scan_sampler_if.slave  bus
);

    localparam int SEL_W = $clog2(N_CH);

    state_e            r_state,     w_state_nxt;
    logic [SEL_W-1:0]  r_ptr,       w_ptr_nxt;
    logic [DATA_W-1:0] r_out_data,  w_data_nxt;
    logic [SEL_W-1:0]  r_out_ch,    w_ch_nxt;
    logic              r_out_valid, w_valid_nxt;
    logic              r_done,      w_done_nxt;

    logic [DATA_W-1:0] w_chan [N_CH];
    logic [SEL_W-1:0]  w_next;
    logic              w_any;
    logic              w_wrapped;
    logic              w_scan;
    logic              w_load_ok;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign w_chan[k] = bus.din[k*DATA_W +: DATA_W];
    end

    // In IDLE the finder searches from index 0 to seed the scan pointer.
    mux_scan_next #(
        .N_CH (N_CH)
    ) u_next (
        .i_ptr       (r_ptr),
        .i_ch_mask   (bus.ch_mask),
        .i_from_zero (r_state == IDLE),
        .o_next      (w_next),
        .o_any       (w_any),
        .o_wrapped   (w_wrapped)
    );

    assign w_scan    = is_scan_mode(bus.mode);
    assign w_load_ok = !r_out_valid || bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_data_nxt  = r_out_data;
        w_ch_nxt    = r_out_ch;
        w_valid_nxt = r_out_valid && !bus.out_ready;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en && (!w_scan || w_any)) begin
                    w_state_nxt = RUN;
                    if (w_scan) begin
                        w_ptr_nxt = w_next;
                    end
                end
            end
            RUN: begin
                if (!bus.en || (w_scan && !w_any)) begin
                    w_state_nxt = IDLE;
                end else if (w_load_ok) begin
                    w_valid_nxt = 1'b1;
                    if (!w_scan) begin
                        w_data_nxt = w_chan[bus.sel];
                        w_ch_nxt   = bus.sel;
                    end else begin
                        w_data_nxt = w_chan[r_ptr];
                        w_ch_nxt   = r_ptr;
                        w_ptr_nxt  = w_next;
                        if ((bus.mode == MODE_SWEEP) && w_wrapped) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_out_data  <= w_data_nxt;
            r_out_ch    <= w_ch_nxt;
            r_out_valid <= w_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;
    assign bus.done      = r_done;

endmodule : mux_scan_sampler
`default_nettype wire

// File: tb/tb_mux_scan_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_sampler
// Description : Directed and randomized checks of mux_scan_sampler against a
//               behavioural sampler model (N_CH=8, DATA_W=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan_sampler;

    localparam int N_CH   = 8;
    localparam int DATA_W = 4;

    logic clk;
    logic rst;

    mux_scan_sampler_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    mux_scan_sampler #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Behavioural model: is a run active, where the scan points, what is held.
    bit m_run;
    int m_ptr;
    bit m_valid;
    int m_data;
    int m_ch;
    bit m_done;

    int seq [8];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int seek(input int start, input logic [7:0] mask);
        for (int k = 0; k < N_CH; k++) begin
            int idx;
            idx = (start + k) % N_CH;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int chan_val(input int k);
        logic [N_CH*DATA_W-1:0] d;
        d = bus.din;
        return int'(d[k*DATA_W +: DATA_W]);
    endfunction

    task automatic model_reset();
        m_run = 0; m_ptr = 0; m_valid = 0; m_data = 0; m_ch = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit scan;
        bit load_ok;
        int nx;
        scan    = (bus.mode == 2'd1) || (bus.mode == 2'd2);
        load_ok = !m_valid || bus.out_ready;
        m_done  = 0;
        if (m_valid && bus.out_ready) m_valid = 0;
        if (!m_run) begin
            if (bus.en && (!scan || bus.ch_mask != 0)) begin
                m_run = 1;
                if (scan) m_ptr = seek(0, bus.ch_mask);
            end
        end else if (!bus.en || (scan && bus.ch_mask == 0)) begin
            m_run = 0;
        end else if (load_ok) begin
            m_valid = 1;
            if (!scan) begin
                m_data = chan_val(int'(bus.sel));
                m_ch   = int'(bus.sel);
            end else begin
                m_data = chan_val(m_ptr);
                m_ch   = m_ptr;
                nx     = seek(m_ptr + 1, bus.ch_mask);
                if (bus.mode == 2'd2 && nx <= m_ptr) begin
                    m_run  = 0;
                    m_done = 1;
                end
                m_ptr = nx;
            end
        end
    endtask

    task automatic compare_outputs();
        check_val("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check_val("done",      32'(bus.done),      32'(m_done));
        check_val("out_data",  32'(bus.out_data),  32'(m_data));
        check_val("out_ch",    32'(bus.out_ch),    32'(m_ch));
    endtask

    // Inputs are only changed 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic mid_cycle_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_data",  32'(bus.out_data),  32'd0);
        check_val("rst_ch",    32'(bus.out_ch),    32'd0);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.mode = 2'd0; bus.sel = '0; bus.ch_mask = '0; bus.out_ready = 1'b1;
        for (int k = 0; k < N_CH; k++) bus.din[k*DATA_W +: DATA_W] = 4'(k + 3);
        #12;
        compare_outputs();
        rst = 1'b0;
        #1;

        // Manual select: channel k carries k+3.
        bus.sel = 3'd5; bus.en = 1'b1;
        step(); step();
        check_val("manual_data5", 32'(bus.out_data), 32'd8);
        check_val("manual_ch5",   32'(bus.out_ch),   32'd5);
        step();
        check_val("manual_hold", 32'(bus.out_data), 32'd8);
        bus.sel = 3'd2;
        step();
        check_val("manual_data2", 32'(bus.out_data), 32'd5);

        // Continuous scan over mask 1010_0110.
        bus.en = 1'b0; step(); step();
        seq = '{1, 2, 5, 7, 1, 2, 5, 7};
        bus.ch_mask = 8'b1010_0110; bus.mode = 2'd1; bus.en = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("scan_seq", 32'(bus.out_ch), 32'(seq[i]));
        end

        // Single sweep over the same mask.
        bus.en = 1'b0; step(); step();
        bus.mode = 2'd2; bus.en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("sweep_seq",  32'(bus.out_ch), 32'(seq[i]));
            check_val("sweep_done", 32'(bus.done),   32'(i == 3));
        end
        bus.en = 1'b0;
        step();
        check_val("sweep_after_valid", 32'(bus.out_valid), 32'd0);

        // Back-pressure in continuous scan.
        step();
        bus.mode = 2'd1; bus.en = 1'b1;
        step(); step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("bp_hold", 32'(bus.out_ch), 32'd1);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check_val("bp_resume", 32'(bus.out_ch), 32'(seq[i]));
        end

        // Empty mask never starts; mask cleared mid-run returns to idle.
        bus.en = 1'b0; step(); step();
        bus.ch_mask = '0; bus.en = 1'b1;
        step(); step(); step();
        check_val("mask0_valid", 32'(bus.out_valid), 32'd0);
        bus.ch_mask = 8'b1010_0110;
        step(); step();
        bus.ch_mask = '0;
        step(); step();
        check_val("maskclr_done", 32'(bus.done), 32'd0);

        // Reset mid-sweep, then restart from the lowest enabled channel.
        bus.ch_mask = 8'b1010_0110; bus.mode = 2'd2;
        step(); step(); step();
        mid_cycle_reset();
        step(); step();
        check_val("restart_ch", 32'(bus.out_ch), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus.din       = 32'($urandom);
            bus.sel       = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.en   = ~bus.en;
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                bus.ch_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 63) == 0) mid_cycle_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_mux_scan_sampler
`default_nettype wire

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Parametrised, registered successor to the single-shot 74151/74150-style multiplexer mappings.
- Selects one of N_CH channels of DATA_W bits each and captures it into an output register (74574-style).
- Presents the result on a valid/ready interface tagged with its channel number.
- Three modes: manual select, continuous round-robin scan, and single-sweep scan. Channels can be skipped via a mask.

Parameters:
N_CH, 8, number of channels; power of two, 2..16
DATA_W, 1, bits per channel
SEL_W, $clog2(N_CH), channel index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
din  in  N_CH*DATA_W  channel data; channel k = din[k*DATA_W +: DATA_W]
en  in  1  run request, level-sensitive
mode  in  2  00 manual, 01 continuous scan, 10 single sweep, 11 reserved (treated as 00)
sel  in  SEL_W  channel select, used in manual mode
ch_mask  in  N_CH  1 = channel enabled for scanning; ignored in manual mode
out_data  out  DATA_W  captured sample
out_ch  out  SEL_W  channel index of out_data
out_valid  out  1  sample available
out_ready  in  1  consumer accepts sample
done  out  1  one-cycle pulse at end of single sweep

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, out_data=0, out_ch=0, out_valid=0, done=0.
- Reset is honoured at any time, including mid-sweep. In-flight samples are discarded.
- States: IDLE, RUN.
- Load condition: RUN and (!out_valid or out_ready).
- "Next enabled": first index with ch_mask bit set, searching circularly from ptr+1 (i.e. strictly after ptr); evaluated with the current-cycle ch_mask.
- IDLE -> RUN when en=1 and (mode manual, or ch_mask!=0).
  - Scan modes: ptr <= first enabled index searching upward from 0.
  - No sample is captured on the transition edge.
- RUN, manual mode, each load edge: out_data <= din[sel], out_ch <= sel, out_valid <= 1.
- RUN, scan mode, each load edge: out_data <= din[ptr], out_ch <= ptr, out_valid <= 1, ptr <= next enabled.
- Single sweep ends when the load just performed is of the highest enabled index (next enabled <= ptr). That edge:
  - state <= IDLE;
  - done=1 for exactly one cycle;
  - out_valid remains 1 until that sample is accepted.
- Latency: en asserted in cycle t, so IDLE->RUN at edge t+1, first load at edge t+2, out_valid visible in cycle t+2.
- Throughput: one sample per cycle while out_ready=1.
- Back-pressure: while out_valid=1 and out_ready=0, out_data, out_ch and ptr hold; din changes are ignored.
- Accept in IDLE: out_valid and out_ready in IDLE clears out_valid.
- en=0 in RUN:
  - No further loads.
  - state <= IDLE at the next edge.
  - A pending sample stays valid until accepted.
- ch_mask=0 in RUN (scan modes): no load; state <= IDLE; done not pulsed.
- Mask changes mid-scan take effect on the next ptr computation. A channel masked after being pointed to is still sampled once.
- Mode change mid-RUN takes effect at the next load edge.
- Single-channel mask: continuous mode resamples that channel every load; single sweep emits one sample then finishes.
- Reserved mode 11 behaves exactly as manual.

Decomposition:
- Package mux_scan_pkg: mode encodings MODE_MANUAL, MODE_SCAN, MODE_SWEEP; state enum IDLE/RUN.
- Sub-module mux_scan_next: purely combinational circular priority finder.
  - Inputs: ptr, ch_mask, from_zero flag.
  - Outputs: next index, any flag, wrapped flag (next <= ptr).
  - Parametrised by N_CH.
- Top level holds FSM, pointer and output register; the data mux is a plain indexed select, so synthesis maps it onto 74151/74150 cells.

Test Plan:
- Manual: N_CH=8, DATA_W=4, din channel k = k+3, sel=5, en=1, out_ready=1 -> from cycle t+2, out_data=8, out_ch=5 every cycle; sel->2 changes out_data to 5 one cycle later.
- Continuous scan: ch_mask=8'b1010_0110, out_ready=1 -> out_ch sequence 1,2,5,7,1,2,... one per cycle; done never asserted.
- Single sweep: same mask -> out_ch 1,2,5,7, then done pulses on the edge loading 7; state IDLE after; out_valid drops after channel-7 accept.
- Back-pressure: scan mode, out_ready=0 for 5 cycles after first sample -> out_data/out_ch stable, ptr held; on out_ready=1 sequence resumes with no channel skipped or duplicated.
- Edge cases: ch_mask=0 with mode=01, en=1 -> stays IDLE, out_valid=0. Mask cleared mid-RUN -> returns to IDLE, no done.
- Reset mid-sweep: assert rst asynchronously between edges while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; restart sweeps from lowest enabled channel.
